// File: rtl/ssd_scan_sequencer.sv
// ---------------------------------------------------------------------------
// ssd_scan_sequencer
//
// Dynamic-scan sequencer for a multiplexed seven-segment display. Each digit
// owns a fixed-length scan slot made of a blank gap followed by 16 PWM
// slices. The first Brightness+1 slices drive the digit and the rest are dark.
// The slot length therefore does not depend on brightness. The segment code
// and brightness are sampled once, on entry to the lit phase, so changes in
// the middle of a slot never glitch the display.
//
// Ports
//   Clock_i          system clock
//   Reset_ni         synchronous, active-low reset
//   Enable_i         1 = scan running, 0 = display dark (scan returns to IDLE)
//   Brightness_i     lit slices per slot = Brightness_i + 1
//   SegmentCodes_i   active-low segment codes, digit i at [8*i +: 8]
//   Segment_o        active-low segment pins (bit 7 = DP)
//   Digital_o        active-low one-hot digit select
//   DigitIndex_o     digit currently owning the scan slot
//   FrameStart_o     one-cycle pulse in the first lit cycle of digit 0
// ---------------------------------------------------------------------------
module ssd_scan_sequencer #(
  parameter int NUM_DIGITS   = 6,
  parameter int SLICE_CYCLES = 3125,
  parameter int GAP_CYCLES   = 64
) (
  input  logic                          Clock_i,
  input  logic                          Reset_ni,
  input  logic                          Enable_i,
  input  logic [3:0]                    Brightness_i,
  input  logic [8*NUM_DIGITS-1:0]       SegmentCodes_i,
  output logic [7:0]                    Segment_o,
  output logic [NUM_DIGITS-1:0]         Digital_o,
  output logic [$clog2(NUM_DIGITS)-1:0] DigitIndex_o,
  output logic                          FrameStart_o
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  // One counter times both the gap and the slices, so it is sized for the
  // longer of the two.
  localparam int CNT_MAX = (SLICE_CYCLES > GAP_CYCLES) ? SLICE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_ON   = 2'd2,
    ST_OFF  = 2'd3
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [3:0]              slice_q;
  logic [3:0]              bright_q;
  logic [IDX_W-1:0]        digit_q;
  logic [IDX_W-1:0]        digit_d;
  logic [7:0]              segment_q;
  logic [NUM_DIGITS-1:0]   digital_q;
  logic                    frame_start_q;

  logic [7:0]              codes [NUM_DIGITS];

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_codes
    assign codes[gi] = SegmentCodes_i[8*gi +: 8];
  end

  always_comb begin
    digit_d = digit_q + 1'b1;
    if (digit_q == IDX_W'(NUM_DIGITS - 1)) begin
      digit_d = '0;
    end
  end

  always_ff @(posedge Clock_i) begin
    frame_start_q <= 1'b0;
    if (!Reset_ni || !Enable_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      slice_q   <= '0;
      bright_q  <= '0;
      digit_q   <= '0;
      segment_q <= '1;
      digital_q <= '1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_q <= ST_GAP;
          digit_q <= '0;
          cnt_q   <= '0;
          slice_q <= '0;
        end
        ST_GAP: begin
          if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
            // Sample code and brightness here so they hold for the whole slot.
            state_q       <= ST_ON;
            cnt_q         <= '0;
            slice_q       <= '0;
            bright_q      <= Brightness_i;
            segment_q     <= codes[digit_q];
            digital_q     <= ~(NUM_DIGITS'(1) << digit_q);
            frame_start_q <= (digit_q == '0);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_ON: begin
          if (cnt_q == CNT_W'(SLICE_CYCLES - 1)) begin
            cnt_q <= '0;
            if (slice_q == bright_q) begin
              segment_q <= '1;
              digital_q <= '1;
              if (bright_q == 4'hF) begin
                // Full brightness: no dark tail, straight to the next gap.
                state_q <= ST_GAP;
                digit_q <= digit_d;
                slice_q <= '0;
              end else begin
                state_q <= ST_OFF;
                slice_q <= slice_q + 1'b1;
              end
            end else begin
              slice_q <= slice_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_OFF: begin
          // The slice index carries on from the lit phase up to 15, so the
          // slot always totals 16 slices.
          if (cnt_q == CNT_W'(SLICE_CYCLES - 1)) begin
            cnt_q <= '0;
            if (slice_q == 4'hF) begin
              state_q <= ST_GAP;
              digit_q <= digit_d;
              slice_q <= '0;
            end else begin
              slice_q <= slice_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          segment_q <= '1;
          digital_q <= '1;
        end
      endcase
    end
  end

  assign Segment_o    = segment_q;
  assign Digital_o    = digital_q;
  assign DigitIndex_o = digit_q;
  assign FrameStart_o = frame_start_q;

endmodule

// File: tb/tb_ssd_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ssd_scan_sequencer
//
// Directed bench for ssd_scan_sequencer with NUM_DIGITS=3, SLICE_CYCLES=4 and
// GAP_CYCLES=2. Each scan slot is expanded into per-cycle expected outputs,
// which are queued and then compared one cycle at a time.
// ---------------------------------------------------------------------------
module tb_ssd_scan_sequencer;

  localparam int ND    = 3;
  localparam int SLICE = 4;
  localparam int GAP   = 2;

  typedef struct packed {
    logic [7:0] seg;
    logic [2:0] dig;
    logic [1:0] idx;
    logic       fs;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [3:0]    bright;
  logic [23:0]   codes_bus;
  logic [7:0]    seg;
  logic [2:0]    dig;
  logic [1:0]    idx;
  logic          fs;

  logic [7:0]    code [ND];
  exp_t          exp_q [$];
  int            vectors     = 0;
  int            miscompares = 0;
  int            cyc         = 0;
  string         tag         = "reset";

  always #5 clk = ~clk;

  ssd_scan_sequencer #(
    .NUM_DIGITS  (ND),
    .SLICE_CYCLES(SLICE),
    .GAP_CYCLES  (GAP)
  ) dut (
    .Clock_i       (clk),
    .Reset_ni      (rst_n),
    .Enable_i      (enable),
    .Brightness_i  (bright),
    .SegmentCodes_i(codes_bus),
    .Segment_o     (seg),
    .Digital_o     (dig),
    .DigitIndex_o  (idx),
    .FrameStart_o  (fs)
  );

  // Digit select must never have more than one active (low) bit.
  always @(negedge clk) begin
    logic onehot_ok;
    onehot_ok = ($countones(~dig) <= 1);
    vectors++;
    assert (onehot_ok === 1'b1) else begin
      miscompares++;
      $error("FAIL onehot cyc=%0d: observed Digital=%b, required at most one low bit", cyc, dig);
    end
  end

  task automatic drive_codes();
    codes_bus = {code[2], code[1], code[0]};
  endtask

  task automatic push_dark(input logic [1:0] d);
    exp_t e;
    e = '{seg: 8'hFF, dig: 3'b111, idx: d, fs: 1'b0};
    exp_q.push_back(e);
  endtask

  // One whole slot: GAP blank cycles, (b+1) lit slices, (15-b) dark slices.
  task automatic push_digit(input int d, input logic [7:0] c, input int b);
    exp_t e;
    logic [2:0] sel;
    sel = 3'b001;
    sel = ~(sel << d);
    for (int k = 0; k < GAP; k++) push_dark(2'(d));
    for (int k = 0; k < (b + 1) * SLICE; k++) begin
      e = '{seg: c, dig: sel, idx: 2'(d), fs: (k == 0 && d == 0)};
      exp_q.push_back(e);
    end
    for (int k = 0; k < (15 - b) * SLICE; k++) push_dark(2'(d));
  endtask

  task automatic step_check();
    exp_t e;
    exp_t o;
    e = exp_q.pop_front();
    @(posedge clk);
    #1;
    cyc++;
    o = {seg, dig, idx, fs};
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d: observed seg=%h dig=%b idx=%0d fs=%b, expected seg=%h dig=%b idx=%0d fs=%b",
             tag, cyc, o.seg, o.dig, o.idx, o.fs, e.seg, e.dig, e.idx, e.fs);
    end
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) step_check();
  endtask

  task automatic drain_all();
    while (exp_q.size() > 0) step_check();
  endtask

  initial begin
    code[0] = 8'hC0;
    code[1] = 8'hF9;
    code[2] = 8'hA4;
    drive_codes();
    rst_n  = 1'b0;
    enable = 1'b0;
    bright = 4'hF;

    // Reset values.
    tag = "reset";
    repeat (2) push_dark(2'd0);
    drain_all();
    rst_n = 1'b1;
    tag = "idle";
    repeat (3) push_dark(2'd0);
    drain_all();

    // Full brightness, two complete frames plus wrap.
    tag = "full_bright";
    enable = 1'b1;
    for (int f = 0; f < 2; f++)
      for (int d = 0; d < ND; d++) push_digit(d, code[d], 15);
    drain_all();

    // Brightness 3: 2 gap + 16 on + 48 off per digit.
    tag = "bright3";
    bright = 4'd3;
    for (int d = 0; d < ND; d++) push_digit(d, code[d], 3);
    drain_all();

    // Brightness 15 -> 0 in the middle of digit 0's lit phase.
    tag = "bright_change";
    bright = 4'hF;
    push_digit(0, code[0], 15);
    push_digit(1, code[1], 0);
    push_digit(2, code[2], 0);
    drain(GAP + 10);
    bright = 4'd0;
    drain_all();

    // Segment code of digit 0 changed mid-ON: visible only from its next slot.
    tag = "code_change";
    push_digit(0, 8'hC0, 0);
    drain(GAP + 2);
    code[0] = 8'h92;
    drive_codes();
    push_digit(1, code[1], 0);
    push_digit(2, code[2], 0);
    push_digit(0, 8'h92, 0);
    drain_all();

    // Enable dropped mid-ON of digit 1, then re-enabled.
    tag = "disable";
    bright = 4'hF;
    push_digit(1, code[1], 15);
    drain(GAP + 10);
    exp_q.delete();
    enable = 1'b0;
    repeat (3) push_dark(2'd0);
    drain_all();
    tag = "reenable";
    enable = 1'b1;
    push_digit(0, code[0], 15);
    push_digit(1, code[1], 15);
    drain_all();

    // One-clock reset in the middle of digit 2's dark phase, Enable held.
    tag = "reset_mid_off";
    bright = 4'd3;
    push_digit(2, code[2], 3);
    drain(GAP + 16 + 5);
    exp_q.delete();
    rst_n = 1'b0;
    push_dark(2'd0);
    drain_all();
    rst_n = 1'b1;
    tag = "restart";
    push_digit(0, code[0], 3);
    push_digit(1, code[1], 3);
    drain_all();

    enable = 1'b0;
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
